// File: rtl/twiddle_multiply.sv
// twiddle_multiply: pipelined complex multiplier for the radix-2^2 SDF FFT.
// It multiplies each butterfly output sample by its twiddle factor and
// rounds the product back to WIDTH bits. The latency is fixed at 3 clocks,
// with no stall or backpressure.
//
// Build option: TWIDDLE_MULTIPLY_SATURATE_EN
//   defined   -> out-of-range results saturate by sign
//   undefined -> out-of-range results wrap (low WIDTH bits kept)
//   The sticky ovf flag is set in both cases.
//
// Twiddles are Q1.(WIDTH-1). Data registers load only on a valid beat, so
// undefined twiddles presented while di_en=0 never reach the outputs.

module twiddle_multiply #(
    parameter int WIDTH = 16,
    parameter int LOG_N = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    input  logic [WIDTH-1:0] tw_re,
    input  logic [WIDTH-1:0] tw_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic [LOG_N-1:0] do_cnt,
    output logic             ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 1;
    localparam logic signed [SW-1:0] RND_HALF = SW'(1) <<< (WIDTH - 2);
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1: registered operands
    logic                    v1_q;
    logic signed [WIDTH-1:0] dr_q, di_q, tr_q, ti_q;

    // Stage 2: partial products
    logic                    v2_q;
    logic signed [PW-1:0]    pr_rr_d, pr_ii_d, pr_ri_d, pr_ir_d;
    logic signed [PW-1:0]    pr_rr_q, pr_ii_q, pr_ri_q, pr_ir_q;

    // Stage 3: sums, rounding, range handling
    logic                    v3_q;
    logic signed [SW-1:0]    re_sum_d, im_sum_d;
    logic signed [SW-1:0]    re_rnd_d, im_rnd_d;
    logic signed [SW-1:0]    re_shf_d, im_shf_d;
    logic [WIDTH-1:0]        re_clip_d, im_clip_d;
    logic                    re_oor_d, im_oor_d;
    logic [WIDTH-1:0]        re_q, im_q;
    logic                    ovf_q, ovf_d;
    logic [LOG_N-1:0]        cnt_q, cnt_d;

    // A shifted sum is in range when every bit above the output sign bit
    // equals that sign bit.
    function automatic logic out_of_range(input logic signed [SW-1:0] s);
        logic [SW-WIDTH:0] top;
        top = s[SW-1:WIDTH-1];
        return !((top == '0) || (top == '1));
    endfunction

    function automatic logic [WIDTH-1:0] clip(input logic signed [SW-1:0] s);
        logic [WIDTH-1:0] r;
`ifdef TWIDDLE_MULTIPLY_SATURATE_EN
        if (out_of_range(s)) begin
            r = s[SW-1] ? NEG_MIN : POS_MAX;
        end else begin
            r = s[WIDTH-1:0];
        end
`else
        r = s[WIDTH-1:0];
`endif
        return r;
    endfunction

    // Stage 1: capture the sample and its twiddle on a valid beat
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q <= 1'b0;
            dr_q <= '0;
            di_q <= '0;
            tr_q <= '0;
            ti_q <= '0;
        end else begin
            v1_q <= di_en;
            if (di_en) begin
                dr_q <= di_re;
                di_q <= di_im;
                tr_q <= tw_re;
                ti_q <= tw_im;
            end
        end
    end

    // Stage 2 products: sign-extend first so each product is full width
    always_comb begin
        pr_rr_d = PW'(dr_q) * PW'(tr_q);
        pr_ii_d = PW'(di_q) * PW'(ti_q);
        pr_ri_d = PW'(dr_q) * PW'(ti_q);
        pr_ir_d = PW'(di_q) * PW'(tr_q);
    end

    // Stage 2: register the four partial products
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v2_q    <= 1'b0;
            pr_rr_q <= '0;
            pr_ii_q <= '0;
            pr_ri_q <= '0;
            pr_ir_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                pr_rr_q <= pr_rr_d;
                pr_ii_q <= pr_ii_d;
                pr_ri_q <= pr_ri_d;
                pr_ir_q <= pr_ir_d;
            end
        end
    end

    // Stage 3 arithmetic: round half toward +inf, then handle range
    always_comb begin
        re_sum_d  = SW'(pr_rr_q) - SW'(pr_ii_q);
        im_sum_d  = SW'(pr_ri_q) + SW'(pr_ir_q);
        re_rnd_d  = re_sum_d + RND_HALF;
        im_rnd_d  = im_sum_d + RND_HALF;
        re_shf_d  = re_rnd_d >>> (WIDTH - 1);
        im_shf_d  = im_rnd_d >>> (WIDTH - 1);
        re_oor_d  = out_of_range(re_shf_d);
        im_oor_d  = out_of_range(im_shf_d);
        re_clip_d = clip(re_shf_d);
        im_clip_d = clip(im_shf_d);
        ovf_d     = ovf_q | (v2_q & (re_oor_d | im_oor_d));
    end

    // Stage 3: output registers and the sticky overflow flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v3_q  <= 1'b0;
            re_q  <= '0;
            im_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            v3_q  <= v2_q;
            ovf_q <= ovf_d;
            if (v2_q) begin
                re_q <= re_clip_d;
                im_q <= im_clip_d;
            end
        end
    end

    // Frame position: the current output shows cnt_q; it advances after each valid output
    always_comb begin
        cnt_d = cnt_q;
        if (v3_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Frame position counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign do_en  = v3_q;
    assign do_re  = re_q;
    assign do_im  = im_q;
    assign do_cnt = cnt_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_twiddle_multiply.sv
// Testbench for twiddle_multiply: directed cases plus random streams
// against a behavioural model (exact integer arithmetic, floor rounding).
// Build option mirrored: TWIDDLE_MULTIPLY_SATURATE_EN

module tb_twiddle_multiply;

    localparam int W  = 16;
    localparam int LN = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          di_en = 1'b0;
    logic [W-1:0]  di_re = '0, di_im = '0, tw_re = '0, tw_im = '0;
    logic          do_en;
    logic [W-1:0]  do_re, do_im;
    logic [LN-1:0] do_cnt;
    logic          ovf;

    twiddle_multiply #(.WIDTH(W), .LOG_N(LN)) dut (
        .clock (clock),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .tw_re (tw_re),
        .tw_im (tw_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im),
        .do_cnt(do_cnt),
        .ovf   (ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int re;
        int im;
        bit ov;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_out    = 0;
    bit   ovf_exp  = 1'b0;
    int   last_re  = 0;
    int   last_im  = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Mathematical floor of x/d for d > 0
    function automatic longint fdiv(input longint x, input longint d);
        longint qt;
        qt = x / d;
        if ((x % d != 0) && (x < 0)) qt = qt - 1;
        return qt;
    endfunction

    function automatic bit oor(input longint v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic int fit(input longint v);
        longint m;
        if (!oor(v)) return int'(v);
`ifdef TWIDDLE_MULTIPLY_SATURATE_EN
        return (v > 0) ? 32767 : -32768;
`else
        m = ((v % 65536) + 65536) % 65536;
        if (m >= 32768) m = m - 65536;
        return int'(m);
`endif
    endfunction

    // Ideal product scaled by 2^-(W-1), rounded half toward +inf
    function automatic void model(input int dr, input int di, input int tr, input int ti,
                                  output int re, output int im, output bit ov);
        longint r, i;
        r  = fdiv(longint'(dr) * tr - longint'(di) * ti + 16384, 32768);
        i  = fdiv(longint'(dr) * ti + longint'(di) * tr + 16384, 32768);
        ov = oor(r) || oor(i);
        re = fit(r);
        im = fit(i);
    endfunction

    function automatic int rnd16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance past the edge
    task automatic run_cycle(input bit en, input int dr, input int di, input int tr, input int ti,
                             input bit use_c, input int cre, input int cim);
        exp_t e;
        int   mre, mim;
        bit   mov;
        di_en = en;
        di_re = dr[W-1:0];
        di_im = di[W-1:0];
        tw_re = tr[W-1:0];
        tw_im = ti[W-1:0];
        if (en) begin
            model(dr, di, tr, ti, mre, mim, mov);
            e.cyc = cyc;
            e.re  = use_c ? cre : mre;
            e.im  = use_c ? cim : mim;
            e.ov  = mov;
            q.push_back(e);
        end
        @(negedge clock);
        if (q.size() > 0 && q[0].cyc + 3 == cyc) begin
            e = q.pop_front();
            if (e.ov) ovf_exp = 1'b1;
            chk("do_en", do_en, 1);
            chk("do_re", $signed(do_re), e.re);
            chk("do_im", $signed(do_im), e.im);
            chk("do_cnt", do_cnt, n_out % 64);
            n_out++;
            last_re = e.re;
            last_im = e.im;
        end else begin
            chk("do_en_idle", do_en, 0);
            chk("do_re_hold", $signed(do_re), last_re);
            chk("do_im_hold", $signed(do_im), last_im);
        end
        chk("ovf", ovf, ovf_exp);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) run_cycle(1'b0, rnd16(), rnd16(), rnd16(), rnd16(), 1'b0, 0, 0);
    endtask

    task automatic rnd_sample();
        run_cycle(1'b1, rnd16(), rnd16(), rnd16(), rnd16(), 1'b0, 0, 0);
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge
    task automatic mid_reset();
        di_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_do_en", do_en, 0);
        chk("rst_do_re", do_re, 0);
        chk("rst_do_im", do_im, 0);
        chk("rst_do_cnt", do_cnt, 0);
        chk("rst_ovf", ovf, 0);
        q.delete();
        n_out   = 0;
        ovf_exp = 1'b0;
        last_re = 0;
        last_im = 0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    initial begin
        int ov_re;
`ifdef TWIDDLE_MULTIPLY_SATURATE_EN
        ov_re = 32767;
`else
        ov_re = -32768;
`endif
        #2 reset = 1'b0;
        #1;
        chk("init_do_en", do_en, 0);
        chk("init_do_re", do_re, 0);
        chk("init_do_im", do_im, 0);
        chk("init_do_cnt", do_cnt, 0);
        chk("init_ovf", ovf, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed: unity, -j, cos(-pi/4) twiddles
        run_cycle(1'b1, 1000, -2000, 32'sh7FFF, 0, 1'b1, 1000, -2000);
        idle(4);
        run_cycle(1'b1, 100, 200, 0, -32768, 1'b1, 200, -100);
        idle(4);
        run_cycle(1'b1, 1000, 0, 32'sh5A82, 32'sh5A82 - 32'sh10000 + 32'sh4AFC, 1'b1, 707, -707);
        idle(4);

        // Overflow corner: -1.0 data times -1.0 twiddle
        run_cycle(1'b1, -32768, 0, -32768, 0, 1'b1, ov_re, 0);
        idle(4);

        // Reset with three samples in flight; nothing stale may emerge
        rnd_sample();
        rnd_sample();
        rnd_sample();
        mid_reset();
        idle(6);

        // Two frames with a gap: counter runs, holds, wraps
        for (int k = 0; k < 64; k++) rnd_sample();
        idle(5);
        for (int k = 0; k < 64; k++) rnd_sample();
        idle(5);

        // Random valid pattern with garbage on idle beats
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 2) != 0) rnd_sample();
            else idle(1);
        end
        idle(6);

        chk("drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
